// File: rtl/we_spi_responder.sv
// we_spi_responder: SPI frame responder sharing the master's clock.
// Accepts 40-bit config frames (spi_sel=0) and 16-bit waveform frames
// (spi_sel=1), MSB first. While a frame is shifted in, the current contents
// of the addressed register are shifted out on miso.
//
// Ports:
//   clk, rst   - system clock; synchronous active-high reset
//   spi_sel    - frame type, latched when the frame starts
//   cs_b       - active-low frame enable
//   mosi       - serial data in
//   miso       - serial readback out (0 outside a frame)
//   clk_out    - one-cycle strobe after each in-length captured bit
//   cfg_msb    - config bits [39:32]
//   cfg_lsb    - config bits [31:0]
//   cfg_valid  - one-cycle pulse on a completed config update
//   dac_word   - last accepted waveform sample
//   dac_valid  - one-cycle pulse on a completed waveform update
//   frame_err  - one-cycle pulse when a frame is rejected (short or overrun)
//   frame_cnt  - count of good frames, wraps at 16 bits
module we_spi_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sel,
  input  logic        cs_b,
  input  logic        mosi,
  output logic        miso,
  output logic        clk_out,
  output logic [7:0]  cfg_msb,
  output logic [31:0] cfg_lsb,
  output logic        cfg_valid,
  output logic [15:0] dac_word,
  output logic        dac_valid,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned WORD_W   = 40;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned CFG_LEN  = 40;
  localparam int unsigned WAVE_LEN = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] rx;
  logic [WORD_W-1:0] tx;
  logic              overrun;
  logic              frame_type;

  logic [CNT_W-1:0]  frame_len_c;
  logic              in_len_c;
  logic              good_c;
  logic [WORD_W-1:0] readback_c;

  // Frame length and acceptance follow the type latched at frame start.
  assign frame_len_c = frame_type ? CNT_W'(WAVE_LEN) : CNT_W'(CFG_LEN);
  assign in_len_c    = bit_cnt < frame_len_c;
  assign good_c      = (bit_cnt == frame_len_c) && !overrun;
  assign readback_c  = spi_sel ? {dac_word, 24'd0} : {cfg_msb, cfg_lsb};

  // tx is cleared when a frame closes, so miso reads 0 outside frames.
  assign miso = tx[WORD_W-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; END always returns to IDLE after one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!cs_b) state_next = ST_SHIFT;
      ST_SHIFT: if (cs_b)  state_next = ST_END;
      ST_END:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Shift datapath, register updates and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      overrun    <= 1'b0;
      frame_type <= 1'b0;
      cfg_msb    <= '0;
      cfg_lsb    <= '0;
      dac_word   <= '0;
      frame_cnt  <= '0;
      clk_out    <= 1'b0;
      cfg_valid  <= 1'b0;
      dac_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_out   <= 1'b0;
      cfg_valid <= 1'b0;
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_b) begin
            // First edge of a frame captures bit 0 and loads the readback.
            frame_type <= spi_sel;
            rx         <= {(WORD_W-1)'(0), mosi};
            bit_cnt    <= CNT_W'(1);
            tx         <= readback_c;
            overrun    <= 1'b0;
            clk_out    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!cs_b) begin
            tx <= {tx[WORD_W-2:0], 1'b0};
            if (bit_cnt != '1) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (in_len_c) begin
              rx      <= {rx[WORD_W-2:0], mosi};
              clk_out <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            // Frame closes: results appear during the END cycle.
            tx <= '0;
            if (good_c) begin
              if (frame_type) begin
                dac_word  <= rx[15:0];
                dac_valid <= 1'b1;
              end else begin
                cfg_msb   <= rx[39:32];
                cfg_lsb   <= rx[31:0];
                cfg_valid <= 1'b1;
              end
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/we_spi_responder.md
WE_SPI_RESPONDER -- requirements
Module: we_spi_responder

Interface
REQ-001 The block SHALL have one clock and one reset. Reset is synchronous and active-high. The ports SHALL be named clk and rst.
REQ-002 Port: clk, input, 1 bit: 512 kHz system clock, the same clock as the SPI master; all logic is on its rising edge.
REQ-003 Port: rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port: spi_sel, input, 1 bit: frame type, 0 = config frame, 1 = waveform frame.
REQ-005 Port: cs_b, input, 1 bit: active-low frame enable.
REQ-006 Port: mosi, input, 1 bit: serial data in, MSB first.
REQ-007 Port: miso, output, 1 bit: serial readback out, MSB first.
REQ-008 Port: clk_out, output, 1 bit: capture strobe, high for one cycle after each accepted bit.
REQ-009 Port: cfg_msb, output, 8 bits: config field bits [39:32].
REQ-010 Port: cfg_lsb, output, 32 bits: config field bits [31:0].
REQ-011 Port: cfg_valid, output, 1 bit: one-cycle pulse when a config update completes.
REQ-012 Port: dac_word, output, 16 bits: last accepted waveform sample.
REQ-013 Port: dac_valid, output, 1 bit: one-cycle pulse when a waveform update completes.
REQ-014 Port: frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-015 Port: frame_cnt, output, 16 bits: count of good frames; wraps from 0xFFFF to 0.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and END.
REQ-017 IDLE SHALL go to SHIFT on the first edge where cs_b is sampled 0. On that edge the block SHALL:
- latch spi_sel into the frame type;
- capture mosi as bit 0;
- set the bit count to 1;
- load the tx register with the readback word.
REQ-018 The readback word SHALL be {cfg_msb, cfg_lsb} for a config frame and {dac_word, 24'd0} for a waveform frame, both 40 bits.
REQ-019 Frame length SHALL be 40 bits for a config frame and 16 bits for a waveform frame.
REQ-020 In SHIFT, while cs_b = 0, each edge SHALL:
- shift mosi into the rx register LSB-side (MSB-first protocol);
- shift tx left by 1;
- increment the 6-bit bit count, saturating at 63.
REQ-021 In SHIFT, while cs_b = 0, edges beyond the frame length SHALL NOT modify rx and SHALL set an internal overrun flag.
REQ-022 miso SHALL equal tx[39]. The readback bit 39-k SHALL be driven during the cycle after capture edge k, for k = 0..39.
REQ-023 miso SHALL be 0 in IDLE.
REQ-024 clk_out SHALL be high for exactly one cycle after each in-length captured bit, and low otherwise.
REQ-025 Changes on spi_sel while in SHIFT SHALL be ignored.
REQ-026 SHIFT SHALL go to END on the first edge where cs_b is sampled 1.
REQ-027 In END, a good frame is one with bit count equal to the frame length and no overrun. For a good frame the block SHALL, on the single END cycle:
- config frame: register cfg_msb = rx[39:32] and cfg_lsb = rx[31:0], and pulse cfg_valid;
- waveform frame: register dac_word = rx[15:0], and pulse dac_valid;
- increment frame_cnt.
REQ-028 Update latency: outputs SHALL change, and the valid pulse SHALL be high, in the cycle after the edge that sampled cs_b = 1.
REQ-029 For a short frame or an overrun frame, END SHALL:
- leave cfg_msb, cfg_lsb, dac_word and frame_cnt unchanged;
- pulse frame_err for one cycle.
REQ-030 END SHALL go to IDLE unconditionally after one cycle.
REQ-031 If cs_b is already 0 during END, the next frame SHALL start on the following edge, so back-to-back frames need a minimum of 1 cycle with cs_b high.
REQ-032 A frame with cs_b low for 0 captured bits cannot occur. A single-bit frame SHALL be treated as short.
REQ-033 cfg_valid, dac_valid and frame_err SHALL be mutually exclusive.
REQ-034 frame_cnt SHALL wrap silently from 0xFFFF to 0x0000.

Reset
REQ-035 When rst = 1 at a clock edge, all of the following SHALL be 0 after that edge:
- state (IDLE);
- bit count, rx, tx and the overrun flag;
- frame type;
- cfg_msb, cfg_lsb, dac_word and frame_cnt;
- miso, clk_out, cfg_valid, dac_valid and frame_err.
REQ-036 rst SHALL take priority over all other inputs.
REQ-037 A reset mid-frame SHALL abort the frame without any valid or err pulse.
REQ-038 After reset, a frame already in progress with cs_b still low SHALL be treated as a new frame starting at the first edge after rst falls.

Verification
REQ-039 Config frame: spi_sel = 0, cs_b low for 40 edges, mosi = 0xA5_1234_5678, then cs_b high. Required:
- cfg_msb = 0xA5 and cfg_lsb = 0x12345678;
- cfg_valid high for exactly 1 cycle, one cycle after cs_b is sampled high;
- frame_cnt = 1.
REQ-040 Readback: after REQ-039, send a second 40-bit config frame. miso SHALL serialize 0xA512345678 MSB first, with one bit per cycle following each capture edge.
REQ-041 Waveform frame: spi_sel = 1, 16 bits 0xBEEF, with spi_sel toggled mid-frame. Required: dac_word = 0xBEEF, one dac_valid pulse, cfg_* unchanged.
REQ-042 Short and overrun frames:
- 39-bit config frame → frame_err pulse, cfg unchanged, frame_cnt unchanged;
- 17-bit waveform frame → frame_err pulse, dac_word unchanged.
REQ-043 Reset: assert rst at bit 20 of a config frame. Required:
- all outputs 0 on the next cycle;
- no valid or err pulse;
- a subsequent full 40-bit frame succeeds with frame_cnt = 1.
REQ-044 Wrap and back-to-back: preload to 65535 good frames, send one more, with back-to-back frames separated by 1 high cycle. Required: frame_cnt = 0, and no frame is lost.
